// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the round-robin grant arbiter
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/idx_onehot8.sv
// rtl/idx_onehot8.sv - combinational 3-bit index to 8-bit one-hot expansion
module idx_onehot8
  import arb_pkg::*;
(
  input  arb_idx_t           idx,
  output logic [N_REQ-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - 8-way round-robin arbiter with registered one-hot grant
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       state, nxt_state;
  arb_idx_t         ptr, nxt_ptr;
  arb_idx_t         nxt_idx;
  logic             nxt_timeout;
  logic [N_REQ-1:0] onehot_d;
  logic [N_REQ-1:0] gnt_d;

  // First requester found walking ptr, ptr+1, ... with 3-bit wraparound.
  function automatic arb_idx_t rr_pick(input logic [N_REQ-1:0] r, input arb_idx_t p);
    arb_idx_t idx;
    arb_idx_t cand;
    logic     found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = p + arb_idx_t'(k);
      if (!found && r[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == ARB_GRANT && nxt_state == ARB_GRANT) begin
      if (hold_cnt != HOLD_W'(MAX_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = |MAX_HOLD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_idx     = gnt_idx;
    nxt_timeout = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          nxt_state = ARB_GRANT;
          nxt_idx   = rr_pick(req, ptr);
        end else begin
          nxt_idx   = '0;
        end
      end
      ARB_GRANT: begin
        // A dropped request wins over a timeout in the same cycle.
        if (!req[gnt_idx]) begin
          nxt_state = ARB_IDLE;
          nxt_idx   = '0;
          nxt_ptr   = gnt_idx + arb_idx_t'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          nxt_state   = ARB_IDLE;
          nxt_idx     = '0;
          nxt_ptr     = gnt_idx + arb_idx_t'(1);
          nxt_timeout = 1'b1;
        end
`endif
      end
      default: begin
        nxt_state = ARB_IDLE;
        nxt_idx   = '0;
      end
    endcase
  end

  idx_onehot8 u_onehot (
    .idx    (nxt_idx),
    .onehot (onehot_d)
  );

  always_comb begin
    gnt_d = '0;
    if (nxt_state == ARB_GRANT)
      gnt_d = onehot_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      gnt_idx   <= nxt_idx;
      gnt_valid <= (nxt_state == ARB_GRANT);
      timeout   <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter (ARB_TIMEOUT_EN optional)
module tb_rr_grant_arbiter;

  typedef struct {
    string      name;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  rr_grant_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic step(input string nm, input logic r, input logic [7:0] rq,
                      input logic v, input logic [2:0] i, input logic t);
    exp_t e;
    rst     = r;
    req     = rq;
    e.name  = nm;
    e.idx   = v ? i : 3'd0;
    e.valid = v;
    e.to    = t;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] eg;
      e  = exp_q.pop_front();
      eg = e.valid ? (8'd1 << e.idx) : 8'd0;
      n_cmp++;
      if (gnt !== eg || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.to) begin
        n_bad++;
        $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, required gnt=%h idx=%0d valid=%b timeout=%b",
                 e.name, gnt, gnt_idx, gnt_valid, timeout, eg, e.idx, e.valid, e.to);
      end
    end
  end

  initial begin
    logic [2:0] g;
    n_cmp = 0;
    n_bad = 0;

    // reset with all requests high
    step("reset0", 1, 8'hFF, 0, 0, 0);
    step("reset1", 1, 8'hFF, 0, 0, 0);
    step("idle",   0, 8'h00, 0, 0, 0);

    // single requester 2
    step("single_grant", 0, 8'h04, 1, 2, 0);
    step("single_hold",  0, 8'h04, 1, 2, 0);
    step("single_rel",   0, 8'h00, 0, 0, 0);

    // full rotation from ptr=0
    step("rot_reset", 1, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      g = 3'(k);
      step("rot_grant", 0, 8'hFF, 1, g, 0);
      step("rot_hold1", 0, 8'hFF, 1, g, 0);
      step("rot_hold2", 0, 8'hFF, 1, g, 0);
      step("rot_drop",  0, 8'hFF & ~(8'd1 << g), 0, 0, 0);
    end
    step("rot_wrap0", 0, 8'hFF, 1, 0, 0);
    step("rot_rel",   0, 8'h00, 0, 0, 0);

    // serve 6 so ptr=7, then 7 before 0, then wrap to 0
    step("g6",        0, 8'h40, 1, 6, 0);
    step("g6_rel",    0, 8'h00, 0, 0, 0);
    step("ptr7_g7",   0, 8'h81, 1, 7, 0);
    step("g7_ignore", 0, 8'h81, 1, 7, 0);
    step("g7_rel",    0, 8'h01, 0, 0, 0);
    step("wrap_g0",   0, 8'h01, 1, 0, 0);
    step("g0_rel",    0, 8'h00, 0, 0, 0);

    // reset mid-grant, then priority restarts at 0
    step("g5",        0, 8'h20, 1, 5, 0);
    step("g5_hold",   0, 8'h20, 1, 5, 0);
    step("mid_rst",   1, 8'h20, 0, 0, 0);
    step("after_g1",  0, 8'h22, 1, 1, 0);
    step("g1_hold",   0, 8'h22, 1, 1, 0);
    step("g1_rel",    0, 8'h20, 0, 0, 0);
    step("then_g5",   0, 8'h20, 1, 5, 0);
    step("g5_rel",    0, 8'h00, 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
    // MAX_HOLD=4 forced release
    step("to_reset", 1, 8'h00, 0, 0, 0);
    step("to_g0_0",  0, 8'h03, 1, 0, 0);
    step("to_g0_1",  0, 8'h03, 1, 0, 0);
    step("to_g0_2",  0, 8'h03, 1, 0, 0);
    step("to_g0_3",  0, 8'h03, 1, 0, 0);
    step("to_pulse", 0, 8'h03, 0, 0, 1);
    step("to_g1_0",  0, 8'h03, 1, 1, 0);
    step("to_g1_1",  0, 8'h03, 1, 1, 0);
    step("to_g1_2",  0, 8'h03, 1, 1, 0);
    step("to_g1_3",  0, 8'h03, 1, 1, 0);
    step("to_pulse2",0, 8'h03, 0, 0, 1);
    step("to_g0_b",  0, 8'h01, 1, 0, 0);
    step("to_g0_b1", 0, 8'h01, 1, 0, 0);
    step("to_g0_b2", 0, 8'h01, 1, 0, 0);
    step("to_g0_b3", 0, 8'h01, 1, 0, 0);
    step("drop_vs_to", 0, 8'h00, 0, 0, 0);
`else
    // grant held indefinitely without the timeout option
    step("long_g3", 0, 8'h08, 1, 3, 0);
    for (int k = 0; k < 20; k++)
      step("long_hold", 0, 8'h08, 1, 3, 0);
    step("long_rel", 0, 8'h00, 0, 0, 0);
`endif

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
